data_memory_sync: RTL and testbench

- Parametrised successor to the current 20-bit data memory for the MIPS datapath.
- Registered one-cycle read with a valid strobe.
- Write-first forwarding when a read and a write hit the same address in the same cycle.
- Out-of-range address detection, plus a post-reset clear sequencer that zeroes every word before accepting accesses.
- Sits between the ALU/address path and the writeback mux of the memory stage.

---
 rtl/data_memory_sync_if.sv | 26 ++
 rtl/data_memory_sync.sv | 104 ++++++++++
 tb/tb_data_memory_sync.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/data_memory_sync_if.sv
// Memory-stage data bus: address/data/strobes from the datapath, registered
// read result and status flags back from the data memory.
interface data_memory_sync_if #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 20
);
  logic [ADDR_W-1:0] read_address;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;
  logic              memwrite;
  logic              memread;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic              busy;
  logic              addr_err;

  modport master (
    output read_address, write_address, write_data, memwrite, memread,
    input  read_data, read_valid, busy, addr_err
  );

  modport slave (
    input  read_address, write_address, write_data, memwrite, memread,
    output read_data, read_valid, busy, addr_err
  );
endinterface

// File: rtl/data_memory_sync.sv
// Data memory for the MIPS memory stage: one-cycle registered read with
// write-first forwarding, range checking and an optional post-reset zero sweep.
module data_memory_sync #(
  parameter int DATA_W         = 20,
  parameter int ADDR_W         = 20,
  parameter int DEPTH          = 1024,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic              clk,
  input logic              rst,
  data_memory_sync_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_t            state;
  logic [PTR_W-1:0]  ptr;
  logic              busy_p1;
  logic              vld_p1;
  logic              addr_err_p1;
  logic [DATA_W-1:0] read_data_p1;

  logic              rd_oor;
  logic              wr_oor;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_val;
  logic [PTR_W-1:0]  rd_idx;
  logic              fwd_hit;

  // Full-width range checks so upper address bits can never alias into the array.
  always_comb begin
    rd_oor  = ({1'b0, bus.read_address}  >= DEPTH_A);
    wr_oor  = ({1'b0, bus.write_address} >= DEPTH_A);
    rd_idx  = bus.read_address[PTR_W-1:0];
    fwd_hit = bus.memwrite && (bus.write_address == bus.read_address);
    wr_en   = 1'b0;
    wr_idx  = bus.write_address[PTR_W-1:0];
    wr_val  = bus.write_data;
    if (!rst) begin
      if (state == CLEAR) begin
        wr_en  = 1'b1;
        wr_idx = ptr;
        wr_val = '0;
      end else begin
        wr_en = bus.memwrite && !wr_oor;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_val;
  end

  // ---- stage p0 -> p1: sample access, register read result and flags ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      vld_p1       <= 1'b0;
      addr_err_p1  <= 1'b0;
      read_data_p1 <= '0;
      if (CLEAR_ON_RESET != 0) begin
        state   <= CLEAR;
        busy_p1 <= 1'b1;
      end else begin
        state   <= READY;
        busy_p1 <= 1'b0;
      end
    end else begin
      case (state)
        CLEAR: begin
          ptr         <= ptr + PTR_W'(1);
          vld_p1      <= 1'b0;
          addr_err_p1 <= 1'b0;
          if (ptr == LAST_PTR) begin
            state   <= READY;
            busy_p1 <= 1'b0;
          end
        end
        default: begin
          vld_p1      <= bus.memread;
          addr_err_p1 <= (bus.memread && rd_oor) || (bus.memwrite && wr_oor);
          if (bus.memread) begin
            if (rd_oor)       read_data_p1 <= '0;
            else if (fwd_hit) read_data_p1 <= bus.write_data;
            else              read_data_p1 <= mem[rd_idx];
          end
        end
      endcase
    end
  end

  assign bus.read_data  = read_data_p1;
  assign bus.read_valid = vld_p1;
  assign bus.busy       = busy_p1;
  assign bus.addr_err   = addr_err_p1;

endmodule

// File: tb/tb_data_memory_sync.sv
// Scoreboard bench for data_memory_sync: one swept 1024-word instance and one
// unswept 1000-word instance, checked through per-instance expectation queues.
module tb_data_memory_sync;

  typedef struct packed {
    logic [19:0] d;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  data_memory_sync_if #(.DATA_W(20), .ADDR_W(20)) ia ();
  data_memory_sync_if #(.DATA_W(20), .ADDR_W(20)) ib ();

  data_memory_sync #(.DATA_W(20), .ADDR_W(20), .DEPTH(1024), .CLEAR_ON_RESET(1))
    u_a (.clk(clk), .rst(rst_a), .bus(ia));
  data_memory_sync #(.DATA_W(20), .ADDR_W(20), .DEPTH(1000), .CLEAR_ON_RESET(0))
    u_b (.clk(clk), .rst(rst_b), .bus(ib));

  exp_t q_a[$];
  exp_t q_b[$];
  bit   eq_a[$];
  bit   eq_b[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ia.memread = 0; ia.memwrite = 0; ia.read_address = 0; ia.write_address = 0; ia.write_data = 0;
    ib.memread = 0; ib.memwrite = 0; ib.read_address = 0; ib.write_address = 0; ib.write_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access cycle; for reads the hand-computed result is queued before the edge.
  task automatic acc(input int which, input bit we, input int wa, input int wd,
                     input bit re, input int ra, input int exp_d, input bit exp_e);
    exp_t x;
    x.d = exp_d[19:0];
    x.e = exp_e;
    if (which == 0) begin
      ia.memwrite = we; ia.write_address = wa[19:0]; ia.write_data = wd[19:0];
      ia.memread = re;  ia.read_address = ra[19:0];
      if (re) q_a.push_back(x);
      else if (exp_e) eq_a.push_back(1'b1);
    end else begin
      ib.memwrite = we; ib.write_address = wa[19:0]; ib.write_data = wd[19:0];
      ib.memread = re;  ib.read_address = ra[19:0];
      if (re) q_b.push_back(x);
      else if (exp_e) eq_b.push_back(1'b1);
    end
    step();
    idle_inputs();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (ia.busy && n < 2000);
  endtask

  // Monitors: pop and compare whenever an instance presents a read or an error.
  always @(negedge clk) begin
    if (ia.read_valid) begin
      if (q_a.size() == 0) check("a_unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_read_data", 32'(ia.read_data), 32'(e.d));
        check("a_read_err", 32'(ia.addr_err), 32'(e.e));
      end
    end else if (ia.addr_err) begin
      if (eq_a.size() == 0) check("a_unexpected_err", 1, 0);
      else check("a_write_err", 32'(ia.addr_err), 32'(eq_a.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (ib.read_valid) begin
      if (q_b.size() == 0) check("b_unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_read_data", 32'(ib.read_data), 32'(e.d));
        check("b_read_err", 32'(ib.addr_err), 32'(e.e));
      end
    end else if (ib.addr_err) begin
      if (eq_b.size() == 0) check("b_unexpected_err", 1, 0);
      else check("b_write_err", 32'(ib.addr_err), 32'(eq_b.pop_front()));
    end
  end

  initial begin
    int n;
    idle_inputs();

    // Unswept 1000-word instance: ready straight out of reset.
    step(); step();
    check("b_busy_in_reset", 32'(ib.busy), 0);
    rst_b = 0;
    step();
    check("b_busy_after_reset", 32'(ib.busy), 0);
    acc(1, 1, 999, 20'h00042, 0, 0, 0, 0);
    acc(1, 0, 0, 0, 1, 999, 20'h00042, 0);
    acc(1, 0, 0, 0, 1, 1000, 20'h00000, 1);
    acc(1, 1, 1000, 20'h11111, 0, 0, 0, 1);
    acc(1, 0, 0, 0, 1, 999, 20'h00042, 0);

    // Swept instance: reset state, then exact sweep length.
    check("a_busy_reset", 32'(ia.busy), 1);
    check("a_valid_reset", 32'(ia.read_valid), 0);
    check("a_data_reset", 32'(ia.read_data), 0);
    check("a_err_reset", 32'(ia.addr_err), 0);
    rst_a = 0;
    count_busy(n);
    check("a_sweep_len", 32'(n), 1024);

    acc(0, 0, 0, 0, 1, 14, 20'h00000, 0);
    acc(0, 1, 5, 20'h12345, 0, 0, 0, 0);
    acc(0, 0, 0, 0, 1, 5, 20'h12345, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("a_hold_data", 32'(ia.read_data), 32'h12345);
      check("a_hold_valid", 32'(ia.read_valid), 0);
    end
    acc(0, 1, 7, 20'hABCDE, 1, 7, 20'hABCDE, 0);
    acc(0, 0, 0, 0, 1, 7, 20'hABCDE, 0);
    acc(0, 1, 1024, 20'hFFFFF, 0, 0, 0, 1);
    acc(0, 0, 0, 0, 1, 0, 20'h00000, 0);
    acc(0, 0, 0, 0, 1, 1023, 20'h00000, 0);
    acc(0, 0, 0, 0, 1, 2000, 20'h00000, 1);

    // Back-to-back reads keep read_valid high each cycle.
    ia.memread = 1; ia.read_address = 5;
    q_a.push_back('{d: 20'h12345, e: 1'b0});
    step();
    ia.read_address = 7;
    q_a.push_back('{d: 20'hABCDE, e: 1'b0});
    step();
    check("a_b2b_valid", 32'(ia.read_valid), 1);
    idle_inputs();
    step();

    // Reset in the middle of a sweep restarts it from zero.
    acc(0, 1, 3, 20'h00777, 0, 0, 0, 0);
    acc(0, 0, 0, 0, 1, 3, 20'h00777, 0);
    rst_a = 1;
    step();
    rst_a = 0;
    ia.memwrite = 1; ia.write_address = 9; ia.write_data = 20'h00555;
    for (int i = 0; i < 500; i++) step();
    check("a_busy_mid", 32'(ia.busy), 1);
    rst_a = 1;
    step();
    check("a_busy_in_rst", 32'(ia.busy), 1);
    rst_a = 0;
    count_busy(n);
    idle_inputs();
    check("a_resweep_len", 32'(n), 1024);
    acc(0, 0, 0, 0, 1, 3, 20'h00000, 0);
    acc(0, 0, 0, 0, 1, 9, 20'h00000, 0);

    step(); step();
    check("a_queue_drained", 32'(q_a.size() + eq_a.size()), 0);
    check("b_queue_drained", 32'(q_b.size() + eq_b.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
